// File: rtl/hamming_secded_codec_pkg.sv
// Shared sizing, code-layout helpers and mode encodings for the Hamming SECDED codec.
package hamming_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Smallest r such that 2^r >= dw + r + 1.
  function automatic int par_w(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  function automatic int code_w(input int dw);
    return dw + par_w(dw) + 1;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) carrying data bit j.
  function automatic int data_pos(input int j);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < j) begin
      pos++;
      if (!is_pow2(pos)) cnt++;
    end
    return pos;
  endfunction

  // Zero-based codeword bit index carrying data bit j.
  function automatic int data_idx(input int j);
    return data_pos(j) - 1;
  endfunction

endpackage

// File: rtl/hamming_secded_codec_if.sv
// Stream, mode and counter signals between the codec and its producer/consumer.
interface hamming_secded_codec_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  localparam int CODE_W = code_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_mode;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic              cnt_clr;
  logic [CNT_W-1:0]  sec_count;
  logic [CNT_W-1:0]  ded_count;

  modport master (
    output in_valid, in_mode, in_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_mode, out_code, out_data, out_sec, out_ded,
           sec_count, ded_count
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_mode, out_code, out_data, out_sec, out_ded,
           sec_count, ded_count
  );
endinterface

// File: rtl/hamming_secded_codec_parity_gen.sv
// Check-bit generator: bit k is the XOR of every position whose index has bit k set.
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  localparam int PAR_W = par_w(DATA_W),
  localparam int N     = DATA_W + PAR_W
) (
  input  logic [N-1:0]     vec_i,
  output logic [PAR_W-1:0] par_o,
  output logic             ovr_o
);

  // With parity fields zeroed this yields the check bits; on a received word it is the syndrome.
  always_comb begin
    par_o = '0;
    for (int k = 0; k < PAR_W; k++) begin
      for (int i = 0; i < N; i++) begin
        if ((((i + 1) >> k) & 1) == 1) par_o[k] = par_o[k] ^ vec_i[i];
      end
    end
  end

  assign ovr_o = ^vec_i;

endmodule

// File: rtl/hamming_secded_codec.sv
// Parametrised SECDED encoder/decoder with a single registered output stage and saturating error counters.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  hamming_secded_codec_if.slave bus
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;

  logic [N-1:0]      enc_vec, enc_full;
  logic [PAR_W-1:0]  enc_par, syn;
  logic              enc_ovr, dec_ovr, dec_p, in_range;
  logic [CODE_W-1:0] enc_code, dec_code;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sec, dec_ded, accept, sec_inc, ded_inc;

  logic              valid_q, mode_q, sec_q, ded_q;
  logic [CODE_W-1:0] code_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    enc_vec = '0;
    for (int j = 0; j < DATA_W; j++) enc_vec[data_idx(j)] = bus.in_data[j];
  end

  hamming_parity_gen #(.DATA_W(DATA_W)) u_enc_par (
    .vec_i (enc_vec),
    .par_o (enc_par),
    .ovr_o (enc_ovr)
  );

  always_comb begin
    enc_full = enc_vec;
    for (int k = 0; k < PAR_W; k++) enc_full[(1 << k) - 1] = enc_par[k];
    enc_code = {enc_ovr ^ (^enc_par), enc_full};
  end

  hamming_parity_gen #(.DATA_W(DATA_W)) u_dec_syn (
    .vec_i (bus.in_data[N-1:0]),
    .par_o (syn),
    .ovr_o (dec_ovr)
  );

  assign dec_p    = dec_ovr ^ bus.in_data[CODE_W-1];
  assign in_range = (int'(syn) <= N);

  // A syndrome beyond N cannot be a single flip, so it is reported as uncorrectable.
  always_comb begin
    dec_code = bus.in_data;
    if (dec_p) begin
      if (syn == '0) dec_code[CODE_W-1] = ~bus.in_data[CODE_W-1];
      for (int i = 0; i < N; i++) begin
        if (syn == PAR_W'(i + 1)) dec_code[i] = ~bus.in_data[i];
      end
    end
    dec_sec = dec_p && in_range;
    dec_ded = (syn != '0) && (!dec_p || !in_range);
    dec_data = '0;
    for (int j = 0; j < DATA_W; j++) dec_data[j] = dec_code[data_idx(j)];
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sec_inc      = accept && (bus.in_mode == MODE_DEC) && dec_sec;
  assign ded_inc      = accept && (bus.in_mode == MODE_DEC) && dec_ded;

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (bus.cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (sec_inc) sec_cnt_d = sat_inc(sec_cnt_q);
      if (ded_inc) ded_cnt_d = sat_inc(ded_cnt_q);
    end
  end

  // Output stage: loads on accept, drains when the consumer takes the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      mode_q    <= 1'b0;
      code_q    <= '0;
      data_q    <= '0;
      sec_q     <= 1'b0;
      ded_q     <= 1'b0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      if (accept) begin
        valid_q <= 1'b1;
        mode_q  <= bus.in_mode;
        if (bus.in_mode == MODE_DEC) begin
          code_q <= dec_code;
          data_q <= dec_data;
          sec_q  <= dec_sec;
          ded_q  <= dec_ded;
        end else begin
          code_q <= enc_code;
          data_q <= bus.in_data[DATA_W-1:0];
          sec_q  <= 1'b0;
          ded_q  <= 1'b0;
        end
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_mode  = mode_q;
  assign bus.out_code  = code_q;
  assign bus.out_data  = data_q;
  assign bus.out_sec   = sec_q;
  assign bus.out_ded   = ded_q;
  assign bus.sec_count = sec_cnt_q;
  assign bus.ded_count = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for the SECDED codec at DATA_W = 4, 8 and 57, plus a narrow-counter instance.
module tb_hamming_secded_codec;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  hamming_secded_codec_if #(.DATA_W(4),  .CNT_W(16)) a_if ();
  hamming_secded_codec_if #(.DATA_W(4),  .CNT_W(2))  b_if ();
  hamming_secded_codec_if #(.DATA_W(8),  .CNT_W(16)) c_if ();
  hamming_secded_codec_if #(.DATA_W(57), .CNT_W(16)) d_if ();

  hamming_secded_codec #(.DATA_W(4),  .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  hamming_secded_codec #(.DATA_W(4),  .CNT_W(2))  u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  hamming_secded_codec #(.DATA_W(8),  .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
  hamming_secded_codec #(.DATA_W(57), .CNT_W(16)) u_d (.clk(clk), .rst(rst), .bus(d_if.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Legacy Hamming(7,4): {d3,d2,d1,p4,d0,p2,p1}
  function automatic logic [6:0] legacy74(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  task automatic xa(input logic m, input logic [7:0] d, output logic [7:0] code,
                    output logic [3:0] data, output logic sec, output logic ded);
    a_if.in_valid = 1'b1; a_if.in_mode = m; a_if.in_data = d; a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    check_eq("a_out_valid", 64'(a_if.out_valid), 64'(1));
    code = a_if.out_code; data = a_if.out_data; sec = a_if.out_sec; ded = a_if.out_ded;
  endtask

  task automatic xc(input logic m, input logic [12:0] d, output logic [12:0] code,
                    output logic [7:0] data, output logic sec, output logic ded);
    c_if.in_valid = 1'b1; c_if.in_mode = m; c_if.in_data = d; c_if.out_ready = 1'b1;
    @(posedge clk); #1;
    c_if.in_valid = 1'b0;
    code = c_if.out_code; data = c_if.out_data; sec = c_if.out_sec; ded = c_if.out_ded;
  endtask

  task automatic xd(input logic m, input logic [63:0] d, output logic [63:0] code,
                    output logic [56:0] data, output logic sec, output logic ded);
    d_if.in_valid = 1'b1; d_if.in_mode = m; d_if.in_data = d; d_if.out_ready = 1'b1;
    @(posedge clk); #1;
    d_if.in_valid = 1'b0;
    code = d_if.out_code; data = d_if.out_data; sec = d_if.out_sec; ded = d_if.out_ded;
  endtask

  logic [7:0]  ac, held;
  logic [3:0]  ad;
  logic [12:0] cc, crx, cc2;
  logic [7:0]  co, cd;
  logic [63:0] dc, drx, dc2;
  logic [56:0] dor, dd;
  logic        s, e;
  int          k, b0, b1;

  initial begin
    a_if.in_valid = 0; a_if.in_mode = 0; a_if.in_data = '0; a_if.out_ready = 1; a_if.cnt_clr = 0;
    b_if.in_valid = 0; b_if.in_mode = 0; b_if.in_data = '0; b_if.out_ready = 1; b_if.cnt_clr = 0;
    c_if.in_valid = 0; c_if.in_mode = 0; c_if.in_data = '0; c_if.out_ready = 1; c_if.cnt_clr = 0;
    d_if.in_valid = 0; d_if.in_mode = 0; d_if.in_data = '0; d_if.out_ready = 1; d_if.cnt_clr = 0;
    a_if.in_valid = 1; a_if.in_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    a_if.in_valid = 0;
    rst = 1'b0;

    check_eq("rst_out_valid", 64'(a_if.out_valid), 64'(0));
    check_eq("rst_in_ready",  64'(a_if.in_ready),  64'(1));
    check_eq("rst_out_code",  64'(a_if.out_code),  64'(0));
    check_eq("rst_sec_count", 64'(a_if.sec_count), 64'(0));
    check_eq("rst_ded_count", 64'(a_if.ded_count), 64'(0));

    // Encode 0xB with junk in the ignored upper bits.
    xa(MODE_ENC, 8'hAB, ac, ad, s, e);
    check_eq("enc_b_code", 64'(ac), 64'(8'h55));
    check_eq("enc_b_data", 64'(ad), 64'(4'hB));
    check_eq("enc_b_sec",  64'(s),  64'(0));
    check_eq("enc_b_ded",  64'(e),  64'(0));
    check_eq("enc_b_mode", 64'(a_if.out_mode), 64'(MODE_ENC));

    for (int v = 0; v < 16; v++) begin
      xa(MODE_ENC, 8'(v), ac, ad, s, e);
      check_eq("enc_legacy", 64'(ac[6:0]), 64'(legacy74(4'(v))));
      check_eq("enc_overall", 64'(ac[7]), 64'(^legacy74(4'(v))));
    end

    xa(MODE_DEC, 8'h55, ac, ad, s, e);
    check_eq("dec_clean_code", 64'(ac), 64'(8'h55));
    check_eq("dec_clean_flags", 64'({s, e}), 64'(0));
    check_eq("dec_mode", 64'(a_if.out_mode), 64'(MODE_DEC));

    xa(MODE_DEC, 8'h45, ac, ad, s, e);
    check_eq("dec_sec_code", 64'(ac), 64'(8'h55));
    check_eq("dec_sec_data", 64'(ad), 64'(4'hB));
    check_eq("dec_sec_flag", 64'({s, e}), 64'(2'b10));
    check_eq("dec_sec_count", 64'(a_if.sec_count), 64'(1));

    xa(MODE_DEC, 8'hD5, ac, ad, s, e);
    check_eq("dec_ovr_code", 64'(ac), 64'(8'h55));
    check_eq("dec_ovr_flag", 64'({s, e}), 64'(2'b10));
    check_eq("dec_ovr_count", 64'(a_if.sec_count), 64'(2));

    xa(MODE_DEC, 8'h56, ac, ad, s, e);
    check_eq("dec_ded_code", 64'(ac), 64'(8'h56));
    check_eq("dec_ded_data", 64'(ad), 64'(4'hB));
    check_eq("dec_ded_flag", 64'({s, e}), 64'(2'b01));
    check_eq("dec_ded_count", 64'(a_if.ded_count), 64'(1));
    check_eq("dec_ded_seckeep", 64'(a_if.sec_count), 64'(2));

    // Backpressure: three words, consumer stalls two cycles on the first.
    @(posedge clk); #1;
    check_eq("bp_idle", 64'(a_if.out_valid), 64'(0));
    a_if.out_ready = 0; a_if.in_valid = 1; a_if.in_mode = MODE_ENC; a_if.in_data = 8'h01;
    @(posedge clk); #1;
    a_if.in_data = 8'h02;
    held = a_if.out_code;
    check_eq("bp_w1_data", 64'(a_if.out_data), 64'(1));
    check_eq("bp_w1_code", 64'(held), 64'({^legacy74(4'h1), legacy74(4'h1)}));
    for (int c = 0; c < 2; c++) begin
      check_eq("bp_in_ready", 64'(a_if.in_ready), 64'(0));
      @(posedge clk); #1;
      check_eq("bp_hold_data", 64'(a_if.out_data), 64'(1));
      check_eq("bp_hold_code", 64'(a_if.out_code), 64'(held));
    end
    a_if.out_ready = 1;
    @(posedge clk); #1;
    check_eq("bp_w2_data", 64'(a_if.out_data), 64'(2));
    a_if.in_data = 8'h03;
    @(posedge clk); #1;
    a_if.in_valid = 0;
    check_eq("bp_w3_data", 64'(a_if.out_data), 64'(3));
    check_eq("bp_w3_valid", 64'(a_if.out_valid), 64'(1));
    @(posedge clk); #1;
    check_eq("bp_drained", 64'(a_if.out_valid), 64'(0));

    // Narrow counters: saturation, then clear beats a coincident event.
    b_if.in_valid = 1; b_if.in_mode = MODE_DEC; b_if.in_data = 8'h45;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("cnt_sat", 64'(b_if.sec_count), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    b_if.cnt_clr = 1;
    @(posedge clk); #1;
    b_if.cnt_clr = 0; b_if.in_valid = 0;
    check_eq("cnt_clr_win", 64'(b_if.sec_count), 64'(0));
    check_eq("cnt_clr_word", 64'(b_if.out_sec), 64'(1));
    @(posedge clk); #1;
    check_eq("cnt_clr_stay", 64'(b_if.sec_count), 64'(0));

    // DATA_W=8: encode, inject 0/1/2 flips, decode.
    for (int i = 0; i < 24; i++) begin
      co = 8'($urandom());
      xc(MODE_ENC, 13'(co), cc, cd, s, e);
      check_eq("c_enc_echo", 64'(cd), 64'(co));
      check_eq("c_enc_even", 64'(^cc), 64'(0));
      k = i % 3;
      crx = cc;
      b0 = int'($urandom_range(12));
      b1 = (b0 + 1 + int'($urandom_range(11))) % 13;
      if (k >= 1) crx[b0] = ~crx[b0];
      if (k == 2) crx[b1] = ~crx[b1];
      xc(MODE_DEC, crx, cc2, cd, s, e);
      check_eq("c_dec_sec", 64'(s), 64'(k == 1));
      check_eq("c_dec_ded", 64'(e), 64'(k == 2));
      if (k < 2) begin
        check_eq("c_dec_data", 64'(cd), 64'(co));
        check_eq("c_dec_code", 64'(cc2), 64'(cc));
      end else begin
        check_eq("c_ded_raw", 64'(cc2), 64'(crx));
      end
    end

    // DATA_W=57 (64-bit codeword).
    for (int i = 0; i < 24; i++) begin
      dor = 57'({$urandom(), $urandom()});
      xd(MODE_ENC, 64'(dor), dc, dd, s, e);
      check_eq("d_enc_echo", 64'(dd), 64'(dor));
      check_eq("d_enc_even", 64'(^dc), 64'(0));
      k = i % 3;
      drx = dc;
      b0 = int'($urandom_range(63));
      b1 = (b0 + 1 + int'($urandom_range(62))) % 64;
      if (k >= 1) drx[b0] = ~drx[b0];
      if (k == 2) drx[b1] = ~drx[b1];
      xd(MODE_DEC, drx, dc2, dd, s, e);
      check_eq("d_dec_sec", 64'(s), 64'(k == 1));
      check_eq("d_dec_ded", 64'(e), 64'(k == 2));
      if (k < 2) begin
        check_eq("d_dec_data", 64'(dd), 64'(dor));
        check_eq("d_dec_code", dc2, dc);
      end else begin
        check_eq("d_ded_raw", dc2, drx);
      end
    end
    check_eq("d_sec_count", 64'(d_if.sec_count), 64'(8));
    check_eq("d_ded_count", 64'(d_if.ded_count), 64'(8));

    // Reset while a result is held.
    @(posedge clk); #1;
    d_if.out_ready = 0; d_if.in_valid = 1; d_if.in_mode = MODE_ENC; d_if.in_data = 64'h1;
    @(posedge clk); #1;
    d_if.in_valid = 0;
    check_eq("rst_mid_held", 64'(d_if.out_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_mid_valid", 64'(d_if.out_valid), 64'(0));
    check_eq("rst_mid_code",  64'(d_if.out_code), 64'(0));
    check_eq("rst_mid_ready", 64'(d_if.in_ready), 64'(1));
    check_eq("rst_mid_cnt",   64'(d_if.sec_count), 64'(0));
    @(posedge clk); #1;
    check_eq("rst_no_replay", 64'(d_if.out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hamming_secded_codec.md
Name: hamming_secded_codec

Overview:
Parametrised Hamming SECDED codec with a registered valid/ready stream interface. It generalises the team's fixed Hamming(7,4) combinational encoder to any DATA_W, adds an overall-parity bit, and supports per-transaction encode or decode mode. Decode performs single-error correction and double-error detection, with saturating error counters. It sits between the tile's data source and the storage or link path, as a drop-in for the 4-bit encoder when DATA_W=4.

Parameters:
DATA_W, 4, data bits per word; supported range 1..57.
CNT_W, 16, width of each saturating error counter.
(derived) PAR_W = smallest r with 2^r >= DATA_W+r+1; N = DATA_W+PAR_W; CODE_W = N+1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input word present
in_ready  out  1  block can accept input
in_mode  in  1  0 = encode, 1 = decode
in_data  in  CODE_W  encode: data in bits [DATA_W-1:0], upper bits ignored; decode: received codeword
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_mode  out  1  mode of held result
out_code  out  CODE_W  encode: codeword; decode: corrected codeword
out_data  out  DATA_W  encode: input data echoed; decode: corrected data (raw on DED)
out_sec  out  1  decode: single error corrected
out_ded  out  1  decode: uncorrectable error detected
cnt_clr  in  1  clear both counters
sec_count  out  CNT_W  saturating count of SEC events
ded_count  out  CNT_W  saturating count of DED events

Behaviour:
- Codeword layout: bit index i in [0,N-1] holds Hamming position i+1. Parity bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, starting from the data LSB. Bit CODE_W-1 is the overall parity: XOR of bits [N-1:0], giving even parity over the full word. For DATA_W=4, bits [6:0] match the legacy 7-bit encoder exactly.
- Parity at position 2^k is the XOR of all data positions whose index has bit k set.
- Decode:
  - S = syndrome, the XOR of the positions of all set bits in [N-1:0]. P = XOR of all CODE_W bits.
  - S=0, P=0: clean; sec=0, ded=0.
  - P=1, S=0: the overall-parity bit is wrong. Flip bit CODE_W-1; sec=1.
  - P=1, 1<=S<=N: flip bit S-1; sec=1.
  - P=1, S>N: ded=1; no correction.
  - P=0, S!=0: ded=1; out_code and out_data are taken from the received word, uncorrected.
- Encode: out_sec and out_ded are 0.
- Handshake and timing:
  - Single output register; latency is 1 cycle from accept to out_valid.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready. On accept, the result loads and out_valid=1 next cycle.
  - When out_valid && out_ready with no accept, out_valid clears next cycle.
  - Accept and drain in the same cycle allow full throughput of 1 word per cycle.
  - While out_valid && !out_ready, all out_* outputs hold stable.
- Counters:
  - On accept of a decode word with sec=1 (resp. ded=1), sec_count (resp. ded_count) increments.
  - Counters saturate at 2^CNT_W-1.
  - cnt_clr zeroes both counters next cycle. If clear coincides with an increment, clear wins and the event is not counted.
- Reset:
  - All outputs go to 0 next clock edge, and in_ready=1 after reset.
  - Reset mid-operation discards any held result; the word is lost and not replayed.
  - in_data is ignored while rst=1.

Decomposition:
- Package hamming_pkg holds:
  - functions par_w(DATA_W) and code_w(DATA_W);
  - function is_pow2(pos);
  - data-to-position mapping functions;
  - constants MODE_ENC=1'b0 and MODE_DEC=1'b1.
- One combinational sub-module, hamming_parity_gen (param DATA_W). It takes an N-bit Hamming vector and returns PAR_W check bits plus the overall XOR. It is shared by the encode path (parity fields zero) and the decode path (syndrome). The top level holds the correction mux, output register, handshake and counters.

Test Plan:
- DATA_W=4, encode in_data=4'hB -> next cycle out_code=8'h55, out_data=4'hB, sec=0, ded=0; all 16 data values match the legacy encoder on [6:0].
- DATA_W=4, decode 8'h45 (bit 4 flipped) -> out_code=8'h55, out_data=4'hB, sec=1, sec_count=1. Decode 8'hD5 (overall bit flipped) -> out_code=8'h55, sec=1.
- DATA_W=4, decode 8'h56 (bits 0,1 flipped) -> ded=1, out_code=8'h56, out_data=4'hB, ded_count=1.
- Back-to-back valid for 3 words, out_ready low for 2 cycles -> in_ready=0 while held, outputs stable, no word dropped or duplicated, order preserved.
- CNT_W=2, 5 single-error decodes, then cnt_clr asserted in the same cycle as a 6th -> count sticks at 3, then reads 0.
- DATA_W=8 and DATA_W=57, random data: encode -> inject 0/1/2 random bit flips -> decode gives the original data with correct sec/ded; rst asserted while out_valid=1 -> out_valid=0 next cycle.
